// File: rtl/md_unit.sv
// HI/LO multiply-divide unit: multi-cycle mult/multu/div/divu with mthi/mtlo moves.
// Optional macro MD_UNIT_CANCEL_EN adds a cancel input that aborts a running operation.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        mthi,
    input  logic        mtlo,
`ifdef MD_UNIT_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    op_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               a_neg, b_neg;
    logic        [31:0] a_mag, b_mag, b_div;
    logic        [31:0] q_mag, r_mag;
    logic        [31:0] res_hi, res_lo;
    logic               res_we;

    // Signed divide works on magnitudes so 0x80000000 / -1 yields 0x80000000 with no overflow trap.
    always_comb begin
        prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u = {32'b0, a_q} * {32'b0, b_q};
        a_neg  = ~op_q[0] & a_q[31];
        b_neg  = ~op_q[0] & b_q[31];
        a_mag  = a_neg ? -a_q : a_q;
        b_mag  = b_neg ? -b_q : b_q;
        b_div  = (b_q == '0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_div;
        r_mag  = a_mag % b_div;
        res_hi = '0;
        res_lo = '0;
        res_we = 1'b1;
        case (op_q)
            2'd0: {res_hi, res_lo} = prod_s;
            2'd1: {res_hi, res_lo} = prod_u;
            default: begin
                res_lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
                res_hi = a_neg ? -r_mag : r_mag;
                res_we = (b_q != '0);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else
`ifdef MD_UNIT_CANCEL_EN
        if (cancel) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else
`endif
        begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= md_op;
                        a_q   <= A;
                        b_q   <= B;
                        cnt   <= md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        if (mthi) hi <= A;
                        if (mtlo) lo <= A;
                    end
                end
                RUN: begin
                    if (cnt == CW'(1)) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (res_we) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit; cancel scenario runs when MD_UNIT_CANCEL_EN is defined.
module tb_md_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        mthi;
    logic        mtlo;
`ifdef MD_UNIT_CANCEL_EN
    logic        cancel;
`endif
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int passed;
    int total;
    int cyc;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .mthi  (mthi),
        .mtlo  (mtlo),
`ifdef MD_UNIT_CANCEL_EN
        .cancel(cancel),
`endif
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches an op, scrambles operands after the start edge, and counts busy cycles (bounded).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        md_op = op;
        A     = a;
        B     = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        cycles = 0;
        while (busy && cycles < 50) begin
            cycles++;
            tick();
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        md_op  = 2'd0;
        A      = '0;
        B      = '0;
        mthi   = 1'b0;
        mtlo   = 1'b0;
`ifdef MD_UNIT_CANCEL_EN
        cancel = 1'b0;
`endif
        #12;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_op(2'd0, 32'hFFFFFFFE, 32'd3, cyc);
        check("mult_cycles", cyc, 32'd5);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFA);

        run_op(2'd1, 32'hFFFFFFFE, 32'd3, cyc);
        check("multu_cycles", cyc, 32'd5);
        check("multu_hi", hi, 32'h00000002);
        check("multu_lo", lo, 32'hFFFFFFFA);

        run_op(2'd0, 32'h80000000, 32'h80000000, cyc);
        check("mult_min_hi", hi, 32'h40000000);
        check("mult_min_lo", lo, 32'h00000000);

        run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
        check("multu_max_hi", hi, 32'hFFFFFFFE);
        check("multu_max_lo", lo, 32'h00000001);

        run_op(2'd2, 32'hFFFFFFF9, 32'd2, cyc);
        check("div_cycles", cyc, 32'd10);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);

        run_op(2'd3, 32'd7, 32'd0, cyc);
        check("divz_cycles", cyc, 32'd10);
        check("divz_lo", lo, 32'hFFFFFFFD);
        check("divz_hi", hi, 32'hFFFFFFFF);

        run_op(2'd2, 32'd7, 32'hFFFFFFFE, cyc);
        check("div_negb_lo", lo, 32'hFFFFFFFD);
        check("div_negb_hi", hi, 32'h00000001);

        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, cyc);
        check("div_ovf_lo", lo, 32'h80000000);
        check("div_ovf_hi", hi, 32'h00000000);

        run_op(2'd3, 32'd100, 32'd7, cyc);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        // start and mthi during busy are ignored
        md_op = 2'd0; A = 32'd6; B = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", {31'b0, busy}, 32'd1);
        tick();
        md_op = 2'd2; A = 32'hDEADBEEF; B = 32'd3; start = 1'b1; mthi = 1'b1;
        tick();
        start = 1'b0; mthi = 1'b0;
        cyc = 0;
        while (busy && cyc < 50) begin
            cyc++;
            tick();
        end
        check("ignore_cycles", cyc, 32'd3);
        check("ignore_hi", hi, 32'd0);
        check("ignore_lo", lo, 32'd42);
        tick();
        check("no_queue_busy", {31'b0, busy}, 32'd0);

        mthi = 1'b1; mtlo = 1'b1; A = 32'h12345678;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        check("mthilo_hi", hi, 32'h12345678);
        check("mthilo_lo", lo, 32'h12345678);

        mtlo = 1'b1; A = 32'hAAAA5555;
        tick();
        mtlo = 1'b0;
        check("mtlo_hi", hi, 32'h12345678);
        check("mtlo_lo", lo, 32'hAAAA5555);

        mthi = 1'b1; mtlo = 1'b1; start = 1'b1; md_op = 2'd1; A = 32'd2; B = 32'd3;
        tick();
        mthi = 1'b0; mtlo = 1'b0; start = 1'b0;
        check("move_start_busy", {31'b0, busy}, 32'd1);
        check("move_start_hi", hi, 32'h12345678);
        check("move_start_lo", lo, 32'hAAAA5555);
        cyc = 0;
        while (busy && cyc < 50) begin
            cyc++;
            tick();
        end
        check("move_start_res_hi", hi, 32'd0);
        check("move_start_res_lo", lo, 32'd6);

        // asynchronous reset mid-division
        md_op = 2'd2; A = 32'd100; B = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        md_op = 2'd0; A = 32'd3; B = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        check("post_rst_busy", {31'b0, busy}, 32'd1);
        cyc = 1;
        while (busy && cyc < 50) begin
            cyc++;
            tick();
        end
        check("post_rst_cycles", cyc, 32'd6);
        check("post_rst_lo", lo, 32'd12);
        check("post_rst_hi", hi, 32'd0);

`ifdef MD_UNIT_CANCEL_EN
        md_op = 2'd2; A = 32'd100; B = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        cancel = 1'b1; mthi = 1'b1; A = 32'h55555555;
        tick();
        cancel = 1'b0; mthi = 1'b0;
        check("cancel_busy", {31'b0, busy}, 32'd0);
        check("cancel_hi", hi, 32'd0);
        check("cancel_lo", lo, 32'd12);
        md_op = 2'd0; A = 32'd5; B = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        check("cancel_restart_busy", {31'b0, busy}, 32'd1);
        cyc = 0;
        while (busy && cyc < 50) begin
            cyc++;
            tick();
        end
        check("cancel_restart_lo", lo, 32'd25);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, launches the operation in md_op when high at a clock edge.
REQ-004 SHALL have port md_op, input, 2, 0=mult, 1=multu, 2=div, 3=divu.
REQ-005 SHALL have port A, input, 32, rs operand (multiplicand / dividend).
REQ-006 SHALL have port B, input, 32, rt operand (multiplier / divisor).
REQ-007 SHALL have port mthi, input, 1, write A into HI.
REQ-008 SHALL have port mtlo, input, 1, write A into LO.
REQ-009 SHALL have port busy, output, 1, an operation is in progress.
REQ-010 SHALL have port hi, output, 32, HI register contents.
REQ-011 SHALL have port lo, output, 32, LO register contents.
REQ-012 SHALL have parameter MULT_CYCLES, default 5, busy cycles for mult and multu.
REQ-013 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div and divu.

Function
REQ-014 SHALL use two states: IDLE and RUN, with a down-counter sized for DIV_CYCLES.
REQ-015 In IDLE, start=1 at an edge SHALL latch A, B and md_op, load the counter with MULT_CYCLES or DIV_CYCLES, and enter RUN; busy SHALL be 1 from the next cycle.
REQ-016 In RUN the counter SHALL decrement each edge; on the edge where it reaches 0, HI/LO SHALL update, busy SHALL fall, and the state SHALL return to IDLE.
REQ-017 busy SHALL be a registered output; hi/lo SHALL show the new result in the same cycle busy first reads 0.
REQ-018 start while busy=1 SHALL be ignored; no queuing.
REQ-019 mult SHALL compute the signed 64-bit product and multu the unsigned 64-bit product; HI takes bits 63:32 and LO bits 31:0.
REQ-020 div/divu SHALL set LO=quotient and HI=remainder; the signed quotient truncates toward zero, and the remainder takes the dividend's sign.
REQ-021 Divide by zero SHALL still occupy DIV_CYCLES, but HI/LO SHALL stay unchanged.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-023 mthi/mtlo SHALL write A into HI/LO at the edge only when busy=0 and start=0; otherwise they are ignored.
REQ-024 mthi and mtlo asserted together SHALL both write A.
REQ-025 Operands SHALL be sampled only at the start edge; later changes to A/B SHALL not affect the result.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, counter=0, busy=0, hi=0 and lo=0, regardless of clk.
REQ-027 Reset during RUN SHALL discard the operation; no partial HI/LO write.
REQ-028 After rst_n is released, the first edge SHALL act as a normal IDLE edge.

Configuration
REQ-029 With macro MD_UNIT_CANCEL_EN defined, the module SHALL add port cancel, input, 1; cancel=1 at an edge SHALL return to IDLE, clear busy the next cycle, leave HI/LO unchanged, and take priority over start, mthi and mtlo at that edge.
REQ-030 Without MD_UNIT_CANCEL_EN, the cancel port and its logic SHALL be absent, and every started operation SHALL run to completion.

Verification
REQ-031 mult with A=0xFFFFFFFE, B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-032 div with A=0xFFFFFFF9 (-7), B=2 -> busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu with A=7, B=0 -> HI/LO unchanged and busy high 10 cycles.
REQ-033 start a mult, then pulse start (div) and mthi at cycle 2 of busy -> both ignored; only the mult result is written.
REQ-034 mthi and mtlo together with A=0x12345678 while idle -> HI=LO=0x12345678 next cycle; with start also high -> no move, and the operation starts.
REQ-035 rst_n pulled low mid-cycle during a div -> busy, hi and lo read 0 before the next clk edge.
REQ-036 With MD_UNIT_CANCEL_EN, cancel at busy cycle 3 of a div -> busy=0 next cycle, HI/LO keep their prior values, and a new start is accepted the following edge.
